// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchronizer plus stability counter that turns a
// bouncing asynchronous push-button into a clean registered level.
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN adds registered one-cycle
// rise/fall pulses that coincide with the new clean value.
module button_debouncer #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_WIDTH     = $clog2(STABLE_CYCLES)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  output logic clean
`ifdef DEBOUNCE_EDGE_PULSE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  // Terminal count: the mismatch has been seen on STABLE_CYCLES consecutive edges.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 clean_q, clean_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;
`endif

  // Next-state: synchronizer shift, and qualify a mismatch for STABLE_CYCLES edges.
  always_comb begin
    sync1_d = button;
    sync2_d = sync1_q;
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      // Any return to the clean level falls through to the default clear above,
      // so a new mismatch always restarts from zero with no partial credit.
      if (cnt_q == CNT_LAST) begin
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
`ifdef DEBOUNCE_EDGE_PULSE_EN
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;
`endif
  end

  // State registers; reset clears everything immediately, even mid-qualification.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
`ifdef DEBOUNCE_EDGE_PULSE_EN
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`endif
    end
  end

  assign clean = clean_q;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  assign rise  = rise_q;
  assign fall  = fall_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer: directed scenarios followed by random
// button/reset activity, checked against a sliding-window reference model
// through an event scoreboard. A second instance with the default parameter
// receives only a short glitch.
`timescale 1ns/1ps
module tb_button_debouncer;

  localparam int SC = 4;

  logic clock    = 1'b0;
  logic reset_n  = 1'b1;
  logic button   = 1'b0;
  logic button_g = 1'b0;
  logic clean;
  logic clean_g;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise, fall, rise_g, fall_g;
`endif

  always #5 clock = ~clock;

  button_debouncer #(.STABLE_CYCLES(SC)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .button (button),
    .clean  (clean)
`ifdef DEBOUNCE_EDGE_PULSE_EN
    ,
    .rise   (rise),
    .fall   (fall)
`endif
  );

  button_debouncer dut_default (
    .clock  (clock),
    .reset_n(reset_n),
    .button (button_g),
    .clean  (clean_g)
`ifdef DEBOUNCE_EDGE_PULSE_EN
    ,
    .rise   (rise_g),
    .fall   (fall_g)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int c;
    bit v;
  } ev_t;
  ev_t evq[$];

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  // Reference model. seen[n] is the value the qualifier observes at edge n
  // after reset release: two reset zeros, then the button samples. clean
  // toggles at edge n when the last SC observed values all differ from clean
  // and that whole window lies after the previous toggle.
  bit bq[$];
  int m_n        = 0;
  bit m_clean    = 1'b0;
  int m_last     = -SC;
  always @(posedge clock) begin
    bit all_diff;
    cyc++;
    if (!reset_n) begin
      bq      = '{1'b0, 1'b0};
      m_n     = 0;
      m_clean = 1'b0;
      m_last  = -SC;
    end else begin
      bq.push_back(button);
      if (m_n >= SC - 1 && m_n - m_last >= SC) begin
        all_diff = 1'b1;
        for (int k = m_n - SC + 1; k <= m_n; k++)
          if (bq[k] == m_clean) all_diff = 1'b0;
        if (all_diff) begin
          m_clean = ~m_clean;
          m_last  = m_n;
          evq.push_back('{cyc, m_clean});
        end
      end
      m_n++;
    end
  end

  // Monitor: consume expected transitions due this cycle and compare outputs.
  bit exp_clean = 1'b0;
  always @(negedge clock) begin
    bit er, ef;
    ev_t e;
    er = 1'b0;
    ef = 1'b0;
    if (!reset_n) begin
      exp_clean = 1'b0;
      evq.delete();
    end
    while (evq.size() > 0 && evq[0].c <= cyc) begin
      e = evq.pop_front();
      exp_clean = e.v;
      er = e.v;
      ef = !e.v;
    end
    chk("clean", clean, exp_clean);
`ifdef DEBOUNCE_EDGE_PULSE_EN
    chk("rise", rise, er);
    chk("fall", fall, ef);
    chk("rise_default", rise_g, 1'b0);
    chk("fall_default", fall_g, 1'b0);
`endif
    chk("clean_default", clean_g, 1'b0);
  end

  // Advance k rising edges, then step just past the edge to drive inputs.
  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #2;
  endtask

  initial begin
    int hold;
    // Reset held with the button pressed: outputs must stay low.
    button = 1'b1;
    #1 reset_n = 1'b0;
    tick(5);
    button  = 1'b0;
    reset_n = 1'b1;
    // Clean press around 200 ns, held.
    tick(14);
    button = 1'b1;
    tick(20);
    // Release.
    button = 1'b0;
    tick(20);
    // Bounce 1,0,1,0 at two cycles per level, then settle high.
    for (int i = 0; i < 4; i++) begin
      button = (i % 2 == 0);
      tick(2);
    end
    button = 1'b1;
    tick(20);
    // Release again.
    button = 1'b0;
    tick(20);
    // Reset mid-qualification with the button still held through release.
    button = 1'b1;
    tick(3);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(20);
    // Exactly-threshold and one-short pulses from a low clean level.
    button = 1'b0;
    tick(20);
    button = 1'b1;
    tick(SC - 1);
    button = 1'b0;
    tick(10);
    button = 1'b1;
    tick(SC);
    button = 1'b0;
    tick(15);
    // Random activity with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        tick($urandom_range(1, 3));
        reset_n = 1'b1;
      end
      button = 1'($urandom_range(0, 1));
      hold   = $urandom_range(1, 2 * SC + 2);
      tick(hold);
    end
    // Three-cycle glitch on the default-parameter instance.
    button_g = 1'b1;
    tick(3);
    button_g = 1'b0;
    tick(30);
    // No expected transition may remain unconsumed.
    total++;
    if (evq.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d want=0", evq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
